// File: rtl/nothing_fifo_pkg.sv
// rtl/nothing_fifo_pkg.sv - shared widths, status header code and status message builder for nothing_fifo
package nothing_fifo_pkg;

  localparam int MSG_WIDTH = 32;
  localparam int OVF_CNT_W = 16;
  localparam logic [7:0] MSG_OVERFLOW = 8'hE1;

  // Header in the top byte, counter in the low bits, zero padding between.
  function automatic logic [MSG_WIDTH-1:0] status_msg(input logic [OVF_CNT_W-1:0] cnt);
    return {MSG_OVERFLOW, {(MSG_WIDTH-8-OVF_CNT_W){1'b0}}, cnt};
  endfunction

endpackage

// File: rtl/nothing_fifo_if.sv
// rtl/nothing_fifo_if.sv - sample stream, message channel and error flag bundle for nothing_fifo
interface nothing_fifo_if #(
  parameter int WDTH = 32
);

  logic [WDTH-1:0]                       in_data;
  logic                                  in_nd;
  logic [nothing_fifo_pkg::MSG_WIDTH-1:0] in_msg;
  logic                                  in_msg_nd;
  logic [WDTH-1:0]                       out_data;
  logic                                  out_nd;
  logic [nothing_fifo_pkg::MSG_WIDTH-1:0] out_msg;
  logic                                  out_msg_nd;
  logic                                  error;

  modport master (
    output in_data, in_nd, in_msg, in_msg_nd,
    input  out_data, out_nd, out_msg, out_msg_nd, error
  );

  modport slave (
    input  in_data, in_nd, in_msg, in_msg_nd,
    output out_data, out_nd, out_msg, out_msg_nd, error
  );

endinterface

// File: rtl/nothing_fifo_mem.sv
// rtl/nothing_fifo_mem.sv - DEPTH x WDTH storage with registered read port, pointers and occupancy
module nothing_fifo_mem #(
  parameter int WDTH  = 32,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [WDTH-1:0] wr_data,
  input  logic            rd_en,
  output logic [WDTH-1:0] rd_data,
  output logic [CW-1:0]   count
);

  logic [WDTH-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Storage carries no reset so it can map onto RAM; reset only blocks writes.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nothing_fifo.sv
// rtl/nothing_fifo.sv - buffered rate-limited pass-through; NOTHING_FIFO_DEBUG_EN adds overflow status messages
module nothing_fifo
  import nothing_fifo_pkg::*;
#(
  parameter int WDTH    = 32,
  parameter int DEPTH   = 8,
  parameter int SPACING = 1
) (
  input  logic          clk,
  input  logic          rst,
  nothing_fifo_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (SPACING > 1) ? $clog2(SPACING) : 1;

  logic [CW-1:0]        count;
  logic [SW-1:0]        spc_cnt;
  logic                 full;
  logic                 rd_issue;
  logic                 wr_en;
  logic                 drop;
  logic                 out_nd_q;
  logic                 error_q;
  logic [WDTH-1:0]      rd_data;
  logic [MSG_WIDTH-1:0] out_msg_q;
  logic                 out_msg_nd_q;

  // A read in the same cycle frees the slot a full FIFO needs for the write.
  assign full     = (count == CW'(DEPTH));
  assign rd_issue = (count != '0) && (spc_cnt == '0);
  assign wr_en    = bus.in_nd && (!full || rd_issue);
  assign drop     = bus.in_nd && full && !rd_issue;

  nothing_fifo_mem #(
    .WDTH  (WDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (bus.in_data),
    .rd_en   (rd_issue),
    .rd_data (rd_data),
    .count   (count)
  );

  // The spacing counter runs down even while empty, so an idle gap earns no burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      spc_cnt  <= '0;
      out_nd_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      if (rd_issue) begin
        spc_cnt <= SW'(SPACING - 1);
      end else if (spc_cnt != '0) begin
        spc_cnt <= spc_cnt - 1'b1;
      end
      out_nd_q <= rd_issue;
      error_q  <= drop;
    end
  end

`ifdef NOTHING_FIFO_DEBUG_EN
  logic [OVF_CNT_W-1:0] ovf_cnt;
  logic [OVF_CNT_W-1:0] ovf_next;
  logic                 pend_v;
  logic [OVF_CNT_W-1:0] pend_cnt;
  logic                 status_v;
  logic [OVF_CNT_W-1:0] status_cnt;

  always_comb begin
    ovf_next   = (ovf_cnt == '1) ? ovf_cnt : ovf_cnt + 1'b1;
    status_v   = drop || pend_v;
    status_cnt = drop ? ovf_next : pend_cnt;
  end

  // Pass-through messages win; a newer overflow replaces any pending status.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt      <= '0;
      pend_v       <= 1'b0;
      pend_cnt     <= '0;
      out_msg_q    <= '0;
      out_msg_nd_q <= 1'b0;
    end else begin
      if (drop) begin
        ovf_cnt <= ovf_next;
      end
      if (bus.in_msg_nd) begin
        out_msg_q    <= bus.in_msg;
        out_msg_nd_q <= 1'b1;
        pend_v       <= status_v;
        pend_cnt     <= status_cnt;
      end else if (status_v) begin
        out_msg_q    <= status_msg(status_cnt);
        out_msg_nd_q <= 1'b1;
        pend_v       <= 1'b0;
      end else begin
        out_msg_q    <= bus.in_msg;
        out_msg_nd_q <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      out_msg_q    <= '0;
      out_msg_nd_q <= 1'b0;
    end else begin
      out_msg_q    <= bus.in_msg;
      out_msg_nd_q <= bus.in_msg_nd;
    end
  end
`endif

  assign bus.out_data   = rd_data;
  assign bus.out_nd     = out_nd_q;
  assign bus.error      = error_q;
  assign bus.out_msg    = out_msg_q;
  assign bus.out_msg_nd = out_msg_nd_q;

endmodule

// File: doc/nothing_fifo.md
# nothing_fifo

Parametrised successor to the plain pass-through `nothing` block: a buffered, rate-limited pass-through for one sample stream plus a message side channel. Samples written with `in_nd` are queued in a DEPTH-entry FIFO and emitted no more often than once every SPACING cycles, which models a slower downstream stage. Overflow is flagged on `error` and counted. It sits anywhere in a QA chain where a stage is needed that holds data without changing it.

## Interface
- WDTH, 32, sample width in bits
- DEPTH, 8, FIFO entries; power of two, minimum 2
- SPACING, 1, minimum cycles between successive `out_nd` pulses; 1 allows back-to-back output
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; synchronous and active-high
- in_data  in  WDTH  input sample
- in_nd  in  1  input sample valid, one sample per cycle
- in_msg  in  `MSG_WIDTH  input message word
- in_msg_nd  in  1  input message valid
- out_data  out  WDTH  output sample, valid only when out_nd=1; reset 0
- out_nd  out  1  output sample valid; reset 0
- out_msg  out  `MSG_WIDTH  output message word; reset 0
- out_msg_nd  out  1  output message valid; reset 0
- error  out  1  one-cycle pulse on each dropped sample; reset 0

## Operation
- State: FIFO storage, write pointer, read pointer, occupancy count (0..DEPTH), spacing counter, 16-bit overflow counter.
- Write: if in_nd=1 and the FIFO is not full, or it is full and a read is issued in the same cycle, in_data is stored at the write pointer.
- Overflow: if in_nd=1, count=DEPTH, and no read is issued that cycle, the sample is dropped. error=1 on the next cycle, and the overflow counter increments, saturating at 16'hFFFF.
- Read issue: occurs in any cycle where count>0 and the spacing counter is 0. The head entry is registered to out_data, with out_nd=1 on the next cycle. The spacing counter then loads SPACING-1 and decrements to 0.
- Pointers wrap modulo DEPTH. Simultaneous read and write leave count unchanged.
- Messages: out_msg and out_msg_nd are in_msg and in_msg_nd delayed one register. Messages are never dropped.
- Data order is strictly preserved. Data values are never altered.

## Timing
- Minimum latency: in_nd at cycle t with the FIFO empty and the spacing counter at 0 gives out_nd at t+2.
- Sustained throughput: one sample per SPACING cycles.
- Message latency: exactly 1 cycle.
- Reset mid-operation: FIFO contents are discarded, count is 0, the spacing counter is 0, and the overflow counter is 0. All outputs are 0 on the cycle after rst is sampled high. Inputs during reset are ignored.
- Full and draining in the same cycle: the write is accepted and error stays 0.
- Empty: no out_nd. The spacing counter keeps counting down regardless of occupancy.

## Configuration
- NOTHING_FIFO_DEBUG_EN defined:
  - On each overflow, the block also emits a status message {MSG_OVERFLOW, overflow_count} on out_msg, with the counter value taken after the increment.
  - If a pass-through message occupies out_msg in the same cycle, the pass-through message goes first. The status message is held in a one-entry pending register and sent in the next free cycle.
  - A further overflow while a status message is pending overwrites the pending message with the newer count.
- Not defined: there are no status messages and out_msg is pure pass-through. The overflow counter is removed; error is unaffected.

## Structure
- The shared package holds MSG_WIDTH, the MSG_OVERFLOW header code (8'hE1 in the top byte), and the 16-bit overflow counter width constant.
- One sub-module, `nothing_fifo_mem`: DEPTH×WDTH storage with a registered read port, plus the pointer and count logic.
- The top level holds spacing control, the error flag, message muxing and the debug pending register.

## Test plan
- SPACING=1, DEPTH=8: in_nd for 5 consecutive cycles with data 1..5 starting at cycle 10 -> out_nd on cycles 12..16 with data 1..5, error never asserted.
- SPACING=3: 4 back-to-back samples A,B,C,D -> outputs at t+2, t+5, t+8, t+11, in order.
- SPACING=4, DEPTH=4: 10 back-to-back samples -> samples 1..4 output first, plus any written while a read freed space. error pulses exactly once per dropped sample, and output order contains no gaps other than the dropped ones.
- Full FIFO with a read issued and in_nd in the same cycle -> the write is accepted, count stays 4, and error=0.
- Reset asserted for 1 cycle while 3 samples are queued -> no further out_nd, and a new sample afterwards appears at t+2.
- With NOTHING_FIFO_DEBUG_EN, an overflow coinciding with in_msg_nd -> the pass-through message appears at t+1 and the status message {8'hE1, count=1} at t+2.
